// File: rtl/segre_sb_drain_ctrl.sv
// Store-buffer drain sequencer: arbitrates the single D$ port between
// pipeline loads and SB drain writes, and forces flushes on full SB / fence.
module segre_sb_drain_ctrl #(
  parameter int WORD_SIZE = 32,
  parameter int MAX_IDLE  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 is_load_i,
  input  logic                 is_store_i,
  input  logic                 is_alu_i,
  input  logic                 fence_i,
  input  logic [WORD_SIZE-1:0] ld_addr_i,
  input  logic                 sb_hit_i,
  input  logic                 sb_empty_i,
  input  logic                 sb_full_i,
  input  logic [WORD_SIZE-1:0] sb_head_addr_i,
  input  logic [WORD_SIZE-1:0] sb_head_data_i,
  output logic                 sb_push_o,
  output logic                 sb_pop_o,
  output logic                 dc_req_o,
  output logic                 dc_we_o,
  output logic [WORD_SIZE-1:0] dc_addr_o,
  output logic [WORD_SIZE-1:0] dc_data_o,
  input  logic                 dc_gnt_i,
  output logic                 pipe_stall_o,
  output logic                 flushing_o
);

  localparam int CNT_W = $clog2(MAX_IDLE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_IDLE);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  logic ld_miss;
  logic wd_fire;
  logic flush_trig;
  logic unused_alu;

  assign unused_alu = is_alu_i;
  assign ld_miss    = is_load_i & ~sb_hit_i;
  assign wd_fire    = (idle_cnt_q == CNT_MAX);
  assign flush_trig = (is_store_i & sb_full_i)
                    | (fence_i & ~sb_empty_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    sb_push_o    = 1'b0;
    sb_pop_o     = 1'b0;
    dc_req_o     = 1'b0;
    dc_we_o      = 1'b0;
    dc_addr_o    = '0;
    dc_data_o    = '0;
    pipe_stall_o = 1'b0;
    flushing_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (flush_trig) begin
          state_d      = FLUSH;
          pipe_stall_o = 1'b1;
        end else if (~sb_empty_i & (~ld_miss | wd_fire)) begin
          dc_req_o     = 1'b1;
          dc_we_o      = 1'b1;
          dc_addr_o    = sb_head_addr_i;
          dc_data_o    = sb_head_data_i;
          sb_pop_o     = dc_gnt_i;
          pipe_stall_o = ld_miss & wd_fire;
          if (!dc_gnt_i) state_d = DRAIN;
        end else if (ld_miss) begin
          dc_req_o     = 1'b1;
          dc_addr_o    = ld_addr_i;
          pipe_stall_o = ~dc_gnt_i;
        end
        sb_push_o = is_store_i & ~sb_full_i & ~pipe_stall_o;
      end
      DRAIN: begin
        dc_req_o     = 1'b1;
        dc_we_o      = 1'b1;
        dc_addr_o    = sb_head_addr_i;
        dc_data_o    = sb_head_data_i;
        sb_pop_o     = dc_gnt_i;
        pipe_stall_o = ld_miss | flush_trig;
        sb_push_o    = is_store_i & ~sb_full_i;
        if (dc_gnt_i) state_d = IDLE;
      end
      FLUSH: begin
        flushing_o   = 1'b1;
        pipe_stall_o = 1'b1;
        if (sb_empty_i) begin
          state_d = IDLE;
        end else begin
          dc_req_o  = 1'b1;
          dc_we_o   = 1'b1;
          dc_addr_o = sb_head_addr_i;
          dc_data_o = sb_head_data_i;
          sb_pop_o  = dc_gnt_i;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog counts IDLE cycles where stores sit undrained
    if (state_q != IDLE || sb_pop_o || sb_empty_i) begin
      idle_cnt_d = '0;
    end else if (!(dc_req_o & dc_we_o) && !wd_fire) begin
      idle_cnt_d = idle_cnt_q + CNT_W'(1);
    end

    if (rst_i) begin
      state_d      = IDLE;
      idle_cnt_d   = '0;
      sb_push_o    = 1'b0;
      sb_pop_o     = 1'b0;
      dc_req_o     = 1'b0;
      dc_we_o      = 1'b0;
      dc_addr_o    = '0;
      dc_data_o    = '0;
      pipe_stall_o = 1'b0;
      flushing_o   = 1'b0;
    end
  end

endmodule

// File: tb/tb_segre_sb_drain_ctrl.sv
// Directed bench for segre_sb_drain_ctrl: inputs change after negedge,
// outputs are checked 1ns later, state advances on posedge.
module tb_segre_sb_drain_ctrl;

  logic        clk;
  logic        rst;
  logic        is_load, is_store, is_alu, fence;
  logic [31:0] ld_addr;
  logic        sb_hit, sb_empty, sb_full;
  logic [31:0] head_addr, head_data;
  logic        push, pop, req, we;
  logic [31:0] addr, data;
  logic        gnt, stall, flushing;

  int checks = 0;
  int errors = 0;

  segre_sb_drain_ctrl #(.WORD_SIZE(32), .MAX_IDLE(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .is_load_i      (is_load),
    .is_store_i     (is_store),
    .is_alu_i       (is_alu),
    .fence_i        (fence),
    .ld_addr_i      (ld_addr),
    .sb_hit_i       (sb_hit),
    .sb_empty_i     (sb_empty),
    .sb_full_i      (sb_full),
    .sb_head_addr_i (head_addr),
    .sb_head_data_i (head_data),
    .sb_push_o      (push),
    .sb_pop_o       (pop),
    .dc_req_o       (req),
    .dc_we_o        (we),
    .dc_addr_o      (addr),
    .dc_data_o      (data),
    .dc_gnt_i       (gnt),
    .pipe_stall_o   (stall),
    .flushing_o     (flushing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic ld, input logic st,
                        input logic alu, input logic fn);
    is_load  = ld;
    is_store = st;
    is_alu   = alu;
    fence    = fn;
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    set_op(0, 0, 1, 0);
    sb_hit = 0; sb_empty = 1; sb_full = 0; gnt = 1;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    // 1: outputs forced low in reset, then push and drain
    rst = 1'b1;
    set_op(0, 1, 0, 0);
    ld_addr = 32'h0; sb_hit = 0;
    sb_empty = 0; sb_full = 0; gnt = 1;
    head_addr = 32'h100; head_data = 32'hAA;
    nxt(); #1;
    chk("rst_req", req, 0);
    chk("rst_push", push, 0);
    chk("rst_pop", pop, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flush", flushing, 0);
    chk("rst_addr", addr, 0);
    nxt();
    rst = 1'b0;
    set_op(0, 1, 0, 0); sb_empty = 1;
    #1;
    chk("t1_push", push, 1);
    chk("t1_noreq", req, 0);
    nxt();
    set_op(0, 0, 1, 0); sb_empty = 0;
    #1;
    chk("t1_req", req, 1);
    chk("t1_we", we, 1);
    chk("t1_addr", addr, 32'h100);
    chk("t1_data", data, 32'hAA);
    chk("t1_pop", pop, 1);
    nxt();

    // 2: watchdog fires after 8 granted load misses
    do_reset();
    set_op(1, 0, 0, 0);
    sb_empty = 0; gnt = 1; ld_addr = 32'h300;
    head_addr = 32'h200; head_data = 32'h22;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2_ld_we", we, 0);
      chk("t2_ld_addr", addr, 32'h300);
      chk("t2_ld_stall", stall, 0);
      nxt();
    end
    #1;
    chk("t2_wd_we", we, 1);
    chk("t2_wd_addr", addr, 32'h200);
    chk("t2_wd_stall", stall, 1);
    chk("t2_wd_pop", pop, 1);
    nxt(); #1;
    chk("t2_after_we", we, 0);
    chk("t2_after_stall", stall, 0);
    nxt();

    // 3: store to full SB flushes 4 entries
    do_reset();
    set_op(0, 1, 0, 0);
    sb_empty = 0; sb_full = 1; gnt = 1;
    head_addr = 32'h700; head_data = 32'h77;
    #1;
    chk("t3_trig_stall", stall, 1);
    chk("t3_trig_push", push, 0);
    chk("t3_trig_req", req, 0);
    nxt();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_fl_state", flushing, 1);
      chk("t3_fl_pop", pop, 1);
      chk("t3_fl_stall", stall, 1);
      chk("t3_fl_push", push, 0);
      nxt();
      sb_full = 0;
    end
    sb_empty = 1;
    #1;
    chk("t3_exit_flush", flushing, 1);
    chk("t3_exit_req", req, 0);
    chk("t3_exit_stall", stall, 1);
    nxt(); #1;
    chk("t3_idle_flush", flushing, 0);
    chk("t3_idle_push", push, 1);
    chk("t3_idle_stall", stall, 0);
    nxt();

    // 4: drain held without grant while a load waits
    do_reset();
    set_op(0, 0, 1, 0);
    sb_empty = 0; gnt = 0;
    head_addr = 32'h400; head_data = 32'h44; ld_addr = 32'h500;
    #1;
    chk("t4_iss_req", req, 1);
    chk("t4_iss_we", we, 1);
    chk("t4_iss_pop", pop, 0);
    nxt();
    set_op(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t4_hold_req", req, 1);
      chk("t4_hold_we", we, 1);
      chk("t4_hold_addr", addr, 32'h400);
      chk("t4_hold_data", data, 32'h44);
      chk("t4_hold_stall", stall, 1);
      chk("t4_hold_pop", pop, 0);
      nxt();
    end
    gnt = 1;
    #1;
    chk("t4_gnt_pop", pop, 1);
    chk("t4_gnt_addr", addr, 32'h400);
    chk("t4_gnt_stall", stall, 1);
    nxt(); #1;
    chk("t4_ld_req", req, 1);
    chk("t4_ld_we", we, 0);
    chk("t4_ld_addr", addr, 32'h500);
    chk("t4_ld_stall", stall, 0);
    nxt();

    // 5: fence with 3 entries, then fence with SB empty
    do_reset();
    set_op(0, 0, 0, 1);
    sb_empty = 0; gnt = 1; head_addr = 32'h600; head_data = 32'h66;
    #1;
    chk("t5_trig_stall", stall, 1);
    chk("t5_trig_flush", flushing, 0);
    nxt();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_fl_pop", pop, 1);
      chk("t5_fl_stall", stall, 1);
      nxt();
    end
    sb_empty = 1;
    #1;
    chk("t5_exit_flush", flushing, 1);
    chk("t5_exit_req", req, 0);
    nxt(); #1;
    chk("t5_empty_stall", stall, 0);
    chk("t5_empty_flush", flushing, 0);
    chk("t5_empty_req", req, 0);
    nxt();

    // 6: reset mid-flush with a write pending
    do_reset();
    set_op(0, 0, 0, 1);
    sb_empty = 0; gnt = 1; head_addr = 32'h800; head_data = 32'h88;
    nxt();
    gnt = 0;
    #1;
    chk("t6_fl_flush", flushing, 1);
    chk("t6_fl_req", req, 1);
    chk("t6_fl_pop", pop, 0);
    nxt();
    rst = 1'b1;
    #1;
    chk("t6_rst_req", req, 0);
    chk("t6_rst_stall", stall, 0);
    chk("t6_rst_flush", flushing, 0);
    nxt();
    rst = 1'b0;
    set_op(0, 0, 1, 0); sb_empty = 1; gnt = 1;
    #1;
    chk("t6_post_flush", flushing, 0);
    chk("t6_post_req", req, 0);
    nxt();
    set_op(1, 0, 0, 0); sb_empty = 0; ld_addr = 32'h900;
    #1;
    chk("t6_post_ld_we", we, 0);
    chk("t6_post_ld_addr", addr, 32'h900);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
